pingpong_ram_ctrl: RTL
======================

Name: pingpong_ram_ctrl

Overview:
Sequences two auto-incrementing sequential-address RAM banks (bank0/bank1) as a ping-pong frame buffer. An upstream writer fills one bank while a downstream reader drains the other. Frames are exactly BLOCK_LEN words long. The controller gates the per-bank wr_req/rd_req strobes, rewinds each bank's address counters through its reset pin, and muxes the read data back to the reader. It sits between a producer stage and a consumer stage in the on-chip memory controller.

Parameters:
DATA_WIDTH, 10, word width
ADDR_WIDTH, 12, bank address width; bank depth is 2^ADDR_WIDTH
BLOCK_LEN, 1024, words per frame; legal range 1..2^ADDR_WIDTH
CNT_W, ADDR_WIDTH+1, width of the internal word counters (derived)

Ports:
clk  in  1  clock; all logic on the rising edge
reset  in  1  synchronous, active-high
wr_valid  in  1  upstream word present
wr_ready  out  1  controller accepts a word this cycle
wr_data  in  DATA_WIDTH  upstream word
rd_req  in  1  downstream pulls one word
rd_avail  out  1  a complete frame is readable
rd_data  out  DATA_WIDTH  read word, valid when rd_data_valid=1
rd_data_valid  out  1  rd_data valid this cycle
rd_last  out  1  with rd_data_valid: last word of the frame
bank_wr_req  out  2  per-bank write strobe
bank_wr_data  out  DATA_WIDTH  write data shared by both banks
bank_rd_req  out  2  per-bank read strobe
bank_clr  out  2  per-bank reset; rewinds address counters and clears rd_data
bank0_rd_data  in  DATA_WIDTH  bank0 read data
bank1_rd_data  in  DATA_WIDTH  bank1 read data

Behaviour:
- Bank interface contract: the bank writes at its own wr_addr and post-increments on wr_req. On rd_req it registers mem[rd_addr] and post-increments. Data appears on bankN_rd_data on the cycle after rd_req. bank_clr zeroes both bank address counters at the next edge.
- Per-bank state: EMPTY, FILL, FULL, DRAIN, CLR.
- Pointers: wr_sel (bank being written) and rd_sel (bank being read), each 1 bit.
- Reset values:
  - both banks EMPTY; wr_sel=0, rd_sel=0; wr_cnt=0, rd_cnt=0.
  - rd_data_valid=0, rd_last=0.
  - bank_clr=2'b11 while reset is high, because bank_clr = {2{reset}} | clr_state.
- Write path:
  - wr_ready = state[wr_sel] is EMPTY or FILL.
  - A word is accepted when wr_valid & wr_ready. In that cycle, bank_wr_req[wr_sel]=1 (combinational) and bank_wr_data=wr_data.
  - On an accept: wr_cnt++. The bank goes EMPTY->FILL on the first word.
  - On the BLOCK_LEN-th word: the bank goes to FULL, wr_cnt is cleared, and wr_sel toggles.
- Read path:
  - rd_avail = state[rd_sel] is FULL or DRAIN.
  - A read is accepted when rd_req & rd_avail. In that cycle, bank_rd_req[rd_sel]=1 (combinational).
  - A rd_req while rd_avail=0 is ignored: no strobe, no state change.
  - On an accept: rd_cnt++. The bank goes FULL->DRAIN on the first read.
  - On the BLOCK_LEN-th read: the bank goes to CLR, rd_cnt is cleared, and rd_sel toggles.
- Read data: latency is 1 cycle.
  - rd_data_valid is registered from the accept.
  - rd_last is registered from the accept with rd_cnt==BLOCK_LEN-1.
  - rd_data = bank selected by the registered rd_sel of the accepting cycle (combinational mux).
- CLR: lasts exactly 1 cycle with bank_clr[b]=1, then the bank goes to EMPTY. The last word's data stays valid because the bank clears only at the end of the CLR cycle.
- BLOCK_LEN=1: EMPTY->FULL directly and FULL->CLR directly; FILL and DRAIN are skipped.
- Simultaneous events:
  - A write completing one bank and a read completing the other in the same cycle are both honoured.
  - A write to a bank is never allowed while that bank is FULL, DRAIN or CLR, so the write and read never target the same bank.
- Back-to-back operation:
  - Writes stall only when both banks are occupied: wr_ready=0 until the read bank passes CLR.
  - Reads continue across the frame boundary with no bubble if the other bank is FULL.
- Reset mid-operation: all state returns to the reset values at the next edge. Partial frames are discarded. Both banks are rewound via bank_clr.

Test Plan:
- BLOCK_LEN=4; write 1,2,3,4 back-to-back ->
  - bank_wr_req=01 for 4 cycles; bank0 FULL; wr_sel=1; rd_avail=1.
  - 4 reads return 1,2,3,4 one cycle after each rd_req, with rd_last on the 4th.
  - bank_clr[0] pulses 1 cycle after the last read.
- Write 8 words 10..17 with no reads ->
  - wr_ready drops after the 8th word.
  - Reads return 10..13 then 14..17 contiguously.
  - wr_ready rises the cycle after bank0 leaves CLR.
- rd_req held high from reset with no writes -> bank_rd_req stays 00 and rd_data_valid stays 0. After 4 writes, first data appears 2 cycles after the 4th write.
- Concurrent streaming: wr_valid and rd_req held high for 40 cycles -> every frame is read in order, no word is lost or duplicated, rd_last fires every 4th valid word.
- Assert reset after 2 words of a frame -> bank_clr=11 during reset and all outputs return to reset values. A new 4-word frame 20..23 then reads back exactly 20..23.
- BLOCK_LEN=1 -> each write produces FULL immediately. Alternate writes and reads return each word with rd_last=1.

Source files
------------

// File: rtl/pingpong_ram_ctrl_if.sv
// Ping-pong frame buffer bus: producer/consumer handshakes plus the
// strobes and read-data returns of the two sequential-address banks.
interface pingpong_ram_ctrl_if #(
  parameter int DATA_WIDTH = 10
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_req;
  logic                  rd_avail;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_data_valid;
  logic                  rd_last;
  logic [1:0]            bank_wr_req;
  logic [DATA_WIDTH-1:0] bank_wr_data;
  logic [1:0]            bank_rd_req;
  logic [1:0]            bank_clr;
  logic [DATA_WIDTH-1:0] bank0_rd_data;
  logic [DATA_WIDTH-1:0] bank1_rd_data;

  modport master (
    output wr_valid,
    output wr_data,
    output rd_req,
    output bank0_rd_data,
    output bank1_rd_data,
    input  wr_ready,
    input  rd_avail,
    input  rd_data,
    input  rd_data_valid,
    input  rd_last,
    input  bank_wr_req,
    input  bank_wr_data,
    input  bank_rd_req,
    input  bank_clr
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    input  rd_req,
    input  bank0_rd_data,
    input  bank1_rd_data,
    output wr_ready,
    output rd_avail,
    output rd_data,
    output rd_data_valid,
    output rd_last,
    output bank_wr_req,
    output bank_wr_data,
    output bank_rd_req,
    output bank_clr
  );
endinterface

// File: rtl/pingpong_ram_ctrl.sv
// Ping-pong controller: one bank fills while the other drains, each bank
// cycling EMPTY -> FILL -> FULL -> DRAIN -> CLR -> EMPTY.
module pingpong_ram_ctrl #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 12,
  parameter int BLOCK_LEN  = 1024,
  parameter int CNT_W      = ADDR_WIDTH + 1
) (
  input  logic               clk,
  input  logic               reset,
  pingpong_ram_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_EMPTY,
    S_FILL,
    S_FULL,
    S_DRAIN,
    S_CLR
  } bank_st_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  bank_st_e         st_q [2];
  bank_st_e         st_d [2];
  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             rvalid_q, rvalid_d;
  logic             rlast_q, rlast_d;
  logic             rsel_q, rsel_d;

  logic wr_ok, rd_ok;
  logic wr_acc, rd_acc;
  logic wr_end, rd_end;

  assign wr_ok  = (st_q[wr_sel_q] == S_EMPTY) ||
                  (st_q[wr_sel_q] == S_FILL);
  assign rd_ok  = (st_q[rd_sel_q] == S_FULL) ||
                  (st_q[rd_sel_q] == S_DRAIN);
  assign wr_acc = bus.wr_valid & wr_ok;
  assign rd_acc = bus.rd_req & rd_ok;
  assign wr_end = (wr_cnt_q == LAST);
  assign rd_end = (rd_cnt_q == LAST);

  always_comb begin
    st_d[0]  = st_q[0];
    st_d[1]  = st_q[1];
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    rvalid_d = rd_acc;
    rlast_d  = rd_acc & rd_end;
    rsel_d   = rd_acc ? rd_sel_q : rsel_q;

    for (int b = 0; b < 2; b++) begin
      if (st_q[b] == S_CLR) st_d[b] = S_EMPTY;
    end

    // write and read banks are disjoint by construction of wr_ok/rd_ok
    if (wr_acc) begin
      if (wr_end) begin
        st_d[wr_sel_q] = S_FULL;
        wr_cnt_d       = '0;
        wr_sel_d       = ~wr_sel_q;
      end else begin
        st_d[wr_sel_q] = S_FILL;
        wr_cnt_d       = wr_cnt_q + ONE;
      end
    end

    if (rd_acc) begin
      if (rd_end) begin
        st_d[rd_sel_q] = S_CLR;
        rd_cnt_d       = '0;
        rd_sel_d       = ~rd_sel_q;
      end else begin
        st_d[rd_sel_q] = S_DRAIN;
        rd_cnt_d       = rd_cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q[0]  <= S_EMPTY;
      st_q[1]  <= S_EMPTY;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rsel_q   <= 1'b0;
    end else begin
      st_q[0]  <= st_d[0];
      st_q[1]  <= st_d[1];
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      rsel_q   <= rsel_d;
    end
  end

  assign bus.wr_ready      = wr_ok;
  assign bus.rd_avail      = rd_ok;
  assign bus.bank_wr_req   = {wr_acc & wr_sel_q, wr_acc & ~wr_sel_q};
  assign bus.bank_rd_req   = {rd_acc & rd_sel_q, rd_acc & ~rd_sel_q};
  assign bus.bank_wr_data  = bus.wr_data;
  assign bus.bank_clr      = {2{reset}} |
                             {st_q[1] == S_CLR, st_q[0] == S_CLR};
  assign bus.rd_data_valid = rvalid_q;
  assign bus.rd_last       = rlast_q;
  // rsel_q holds the bank of the last accepted read, so data lines up
  assign bus.rd_data       = rsel_q ? bus.bank1_rd_data
                                    : bus.bank0_rd_data;

endmodule
